// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller between peripheral request lines and the CPU.
// Each request line passes through a synchroniser. It is then latched into the
// pending register, either as a rising edge or as a level. Pending requests are
// masked, and the lowest set bit wins arbitration. Software runs a REQ/ACK/EOI
// handshake through four byte registers.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high
//   AD   - register select: 0 PEND, 1 MASK, 2 MODE, 3 VEC
//   DI   - write data from the CPU
//   DO   - read data to the CPU, combinational from the registers
//   rw   - 1 = read, 0 = write
//   cs   - chip select
//   src  - asynchronous request lines
//   intr - registered interrupt request to the CPU
module irq_ctrl #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       AD,
  input  logic [7:0]       DI,
  output logic [7:0]       DO,
  input  logic             rw,
  input  logic             cs,
  input  logic [N_SRC-1:0] src,
  output logic             intr
);

  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, SERV = 2'b10} state_t;

  localparam logic [8:0] SRC_TOP  = 9'(1) << N_SRC;
  localparam logic [7:0] SRC_MASK = 8'(SRC_TOP - 9'd1);

  // Lowest set bit has the highest priority.
  function automatic logic [2:0] prio(input logic [7:0] v);
    prio = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) prio = 3'(i);
    end
  endfunction

  logic [7:0] src_ext;
  logic [7:0] sync_p [SYNC_STAGES];
  logic [7:0] sync_out;
  logic [7:0] hist_p;
  logic [7:0] pend, mask, mode;
  logic [7:0] pend_nxt, edge_set, w1c, ack_clr, act;
  logic [2:0] cur, cur_nxt;
  logic       intr_nxt;
  logic       wr, vec_wr;
  state_t     state, state_nxt;

  assign src_ext  = 8'(src);
  assign wr       = cs && !rw;
  assign vec_wr   = wr && (AD == 2'd3);
  assign sync_out = sync_p[SYNC_STAGES-1];

  // ---- stage: input synchroniser and edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= 8'd0;
      hist_p <= 8'd0;
    end else begin
      sync_p[0] <= src_ext;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      hist_p <= sync_out;
    end
  end

  // Edge-mode bits are sticky, and a new edge beats a clear that arrives in
  // the same cycle. Level-mode bits simply follow the synchronised line.
  assign edge_set = sync_out & ~hist_p;
  assign w1c      = (wr && AD == 2'd0) ? DI : 8'd0;
  assign pend_nxt = SRC_MASK & ((mode & ((pend & ~w1c & ~ack_clr) | edge_set))
                              | (~mode & sync_out));
  assign act      = pend & mask;

  // ---- stage: pending / mask / mode registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 8'd0;
      mask <= 8'd0;
      mode <= 8'd0;
    end else begin
      pend <= pend_nxt;
      if (wr && AD == 2'd1) mask <= DI & SRC_MASK;
      if (wr && AD == 2'd2) mode <= DI & SRC_MASK;
    end
  end

  // Handshake FSM. cur is frozen while in REQ, so a higher-priority request
  // that arrives during REQ waits for the next arbitration in IDLE.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    intr_nxt  = intr;
    ack_clr   = 8'd0;
    case (state)
      IDLE: begin
        intr_nxt = 1'b0;
        if (act != 8'd0) begin
          state_nxt = REQ;
          cur_nxt   = prio(act);
          intr_nxt  = 1'b1;
        end
      end
      REQ: begin
        if (vec_wr) begin
          state_nxt = SERV;
          intr_nxt  = 1'b0;
          ack_clr   = (8'd1 << cur) & mode;
        end else if (!act[cur]) begin
          // The request was withdrawn before software acknowledged it.
          state_nxt = IDLE;
          intr_nxt  = 1'b0;
        end
      end
      SERV: begin
        intr_nxt = 1'b0;
        if (vec_wr) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        intr_nxt  = 1'b0;
      end
    endcase
  end

  // ---- stage: FSM state, current vector and interrupt output
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur   <= 3'd0;
      intr  <= 1'b0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      intr  <= intr_nxt;
    end
  end

  always_comb begin
    DO = 8'd0;
    case (AD)
      2'd0: DO = pend;
      2'd1: DO = mask;
      2'd2: DO = mode;
      2'd3: DO = {state, 3'b000, cur};
      default: DO = 8'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed bench for irq_ctrl with the default parameters
// (N_SRC = 8, SYNC_STAGES = 2). Expected values are hand-computed.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic [7:0] src;
  logic       intr;

  int vectors = 0;
  int errs    = 0;

  irq_ctrl #(.N_SRC(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO),
    .rw(rw), .cs(cs), .src(src), .intr(intr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input string tag, input logic [7:0] exp);
    AD = a; rw = 1'b1; cs = 1'b1;
    #1;
    check(tag, DO, exp);
    cs = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    AD = a; DI = d; rw = 1'b0; cs = 1'b1;
    tick();
    cs = 1'b0; rw = 1'b1; DI = 8'd0;
  endtask

  initial begin
    rst = 1'b1; AD = 2'd0; DI = 8'd0; rw = 1'b1; cs = 1'b0; src = 8'd0;
    tick(2);
    rst = 1'b0;

    // Reset state
    rd(2'd0, "rst_pend", 8'h00);
    rd(2'd1, "rst_mask", 8'h00);
    rd(2'd2, "rst_mode", 8'h00);
    rd(2'd3, "rst_vec",  8'h00);
    check("rst_intr", {7'd0, intr}, 8'h00);

    // 1: pulse src[0] in edge mode while masked
    wr(2'd2, 8'h01);
    src[0] = 1'b1; tick(); src[0] = 1'b0;
    tick(4);
    rd(2'd0, "t1_pend", 8'h01);
    rd(2'd3, "t1_vec",  8'h00);
    check("t1_intr", {7'd0, intr}, 8'h00);

    // 2: enabled edge source, latency and handshake
    wr(2'd0, 8'h01);
    rd(2'd0, "t2_w1c", 8'h00);
    wr(2'd1, 8'h01);
    src[0] = 1'b1;
    tick(3);
    check("t2_intr_early", {7'd0, intr}, 8'h00);
    tick();
    check("t2_intr", {7'd0, intr}, 8'h01);
    rd(2'd3, "t2_vec_req", 8'h40);
    wr(2'd3, 8'h00);
    check("t2_intr_ack", {7'd0, intr}, 8'h00);
    rd(2'd0, "t2_pend_ack", 8'h00);
    rd(2'd3, "t2_vec_serv", 8'h80);
    wr(2'd3, 8'h00);
    rd(2'd3, "t2_vec_eoi", 8'h00);
    src[0] = 1'b0;
    tick(4);

    // 3: simultaneous edges, lower index wins, the other follows after EOI
    wr(2'd2, 8'h06);
    wr(2'd1, 8'h06);
    src[2:1] = 2'b11;
    tick(4);
    check("t3_intr", {7'd0, intr}, 8'h01);
    rd(2'd3, "t3_vec1", 8'h41);
    wr(2'd3, 8'h00);
    rd(2'd3, "t3_vec_serv", 8'h81);
    rd(2'd0, "t3_pend_ack", 8'h04);
    wr(2'd3, 8'h00);
    check("t3_intr_eoi", {7'd0, intr}, 8'h00);
    tick();
    check("t3_intr_rerise", {7'd0, intr}, 8'h01);
    rd(2'd3, "t3_vec2", 8'h42);
    wr(2'd3, 8'h00);
    wr(2'd3, 8'h00);
    src[2:1] = 2'b00;
    tick(4);

    // 4: level source held high re-raises after EOI
    wr(2'd2, 8'h00);
    wr(2'd1, 8'h08);
    src[3] = 1'b1;
    tick(4);
    rd(2'd3, "t4_vec", 8'h43);
    wr(2'd3, 8'h00);
    rd(2'd0, "t4_pend_level", 8'h08);
    wr(2'd3, 8'h00);
    check("t4_intr_eoi", {7'd0, intr}, 8'h00);
    tick();
    check("t4_intr_rerise", {7'd0, intr}, 8'h01);
    rd(2'd3, "t4_vec_rerise", 8'h43);
    wr(2'd3, 8'h00);
    src[3] = 1'b0;
    tick(3);
    rd(2'd0, "t4_pend_fell", 8'h00);
    wr(2'd3, 8'h00);
    tick(2);
    check("t4_intr_idle", {7'd0, intr}, 8'h00);
    rd(2'd3, "t4_vec_idle", 8'h03);

    // 5: masking before ACK withdraws the request
    wr(2'd2, 8'h01);
    wr(2'd1, 8'h01);
    src[0] = 1'b1;
    tick(4);
    rd(2'd3, "t5_vec_req", 8'h40);
    wr(2'd1, 8'h00);
    tick();
    check("t5_intr", {7'd0, intr}, 8'h00);
    rd(2'd3, "t5_vec", 8'h00);
    rd(2'd0, "t5_pend", 8'h01);

    // 6: reset while in SERV
    wr(2'd1, 8'h01);
    tick();
    wr(2'd3, 8'h00);
    rd(2'd3, "t6_vec_serv", 8'h80);
    rst = 1'b1;
    tick();
    rd(2'd3, "t6_vec", 8'h00);
    rd(2'd1, "t6_mask", 8'h00);
    rd(2'd2, "t6_mode", 8'h00);
    rd(2'd0, "t6_pend", 8'h00);
    check("t6_intr", {7'd0, intr}, 8'h00);
    rst = 1'b0;
    src[0] = 1'b0;
    tick(4);

    // W1C coincident with a new edge: set wins
    wr(2'd2, 8'h01);
    src[0] = 1'b1;
    tick(4);
    src[0] = 1'b0;
    tick(3);
    rd(2'd0, "t7_pend_pre", 8'h01);
    src[0] = 1'b1;
    tick(2);
    wr(2'd0, 8'h01);
    rd(2'd0, "t7_set_wins", 8'h01);
    wr(2'd0, 8'h01);
    rd(2'd0, "t7_w1c", 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
